dma_cl_unpacker: RTL and testbench

Read-side counterpart of the AFU result packer. It pulls 512-bit cache lines from the DMA read channel and serializes each line into 16 32-bit words on a valid/ready stream. The stream feeds the AFU compute blocks, such as mod_exp operand or key loading and RO configuration. It counts lines and words so that software can hand it a buffer of num_lines cache lines, and it raises done when the last word has been accepted downstream.

---
 rtl/dma_cl_unpacker.sv | 100 ++++++++++
 tb/tb_dma_cl_unpacker.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cl_unpacker.sv
// Cache-line unpacker: pops 512-bit DMA read lines and emits them LSB-first as 32-bit words.
// Latency: first out_valid one cycle after the first dma_rd_en; then one word per cycle with no bubble between lines.
// Backpressure: out_data holds while out_valid && !out_ready; the DMA is popped only when the line buffer is free or draining.
module dma_cl_unpacker #(
    parameter int CL_DATA_WIDTH = 512,
    parameter int WORD_WIDTH    = 32,
    parameter int SIZE_WIDTH    = 65
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go,
    input  logic [SIZE_WIDTH-1:0]    num_lines,
    input  logic                     dma_empty,
    input  logic [CL_DATA_WIDTH-1:0] dma_rd_data,
    output logic                     dma_rd_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORD_WIDTH-1:0]    out_data,
    output logic                     out_last,
    output logic                     done
);

    localparam int WORDS_PER_CL = CL_DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W        = $clog2(WORDS_PER_CL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_CL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [SIZE_WIDTH-1:0]    num_lines_q;
    logic [SIZE_WIDTH-1:0]    lines_read_q;
    logic [CL_DATA_WIDTH-1:0] buf_q;
    logic                     buf_valid_q;
    logic [IDX_W-1:0]         word_idx_q;

    logic out_fire;
    logic last_word_accept;

    // Handshake and refill decisions; the refill may coincide with the last word's accept for zero-bubble streaming.
    always_comb begin
        out_valid        = buf_valid_q && (state_q == RUN);
        out_fire         = out_valid && out_ready;
        last_word_accept = out_fire && (word_idx_q == LAST_IDX);
        dma_rd_en        = (state_q == RUN) && !dma_empty &&
                           (lines_read_q < num_lines_q) &&
                           (!buf_valid_q || last_word_accept);
        out_last         = out_valid && (word_idx_q == LAST_IDX) &&
                           (lines_read_q == num_lines_q);
        done             = (state_q == DONE);
    end

    // Word select: word k sits at bits [k*WORD_WIDTH +: WORD_WIDTH], lowest word first.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < WORDS_PER_CL; k++) begin
            if (word_idx_q == IDX_W'(k)) begin
                out_data = buf_q[k*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Control FSM with line buffer and counters; go restarts from any state and discards a partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            num_lines_q  <= '0;
            lines_read_q <= '0;
            buf_q        <= '0;
            buf_valid_q  <= 1'b0;
            word_idx_q   <= '0;
        end else if (go) begin
            num_lines_q  <= num_lines;
            lines_read_q <= '0;
            buf_valid_q  <= 1'b0;
            word_idx_q   <= '0;
            state_q      <= (num_lines == '0) ? DONE : RUN;
        end else begin
            if (dma_rd_en) begin
                buf_q        <= dma_rd_data;
                buf_valid_q  <= 1'b1;
                word_idx_q   <= '0;
                lines_read_q <= lines_read_q + SIZE_WIDTH'(1);
            end else if (out_fire) begin
                if (word_idx_q != LAST_IDX) begin
                    word_idx_q <= word_idx_q + IDX_W'(1);
                end else begin
                    buf_valid_q <= 1'b0;
                end
            end
            if (out_fire && out_last) begin
                state_q <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_dma_cl_unpacker.sv
// Bench for dma_cl_unpacker: FIFO model feeds lines, accepted words are compared against the flattened line list.
// Latency: one cycle per tick; inputs driven at negedge, outputs sampled 1 ns later.
// Backpressure: out_ready patterns are always-on, alternating, or held low for a single tick.
module tb_dma_cl_unpacker;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go = 1'b0;
    logic [64:0]  num_lines = '0;
    logic         dma_empty = 1'b1;
    logic [511:0] dma_rd_data = '0;
    logic         dma_rd_en;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [31:0]  out_data;
    logic         out_last;
    logic         done;

    dma_cl_unpacker dut (
        .clk(clk), .rst(rst), .go(go), .num_lines(num_lines),
        .dma_empty(dma_empty), .dma_rd_data(dma_rd_data), .dma_rd_en(dma_rd_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [511:0] fifo[$];
    logic [31:0]  exp_w[$];
    logic [31:0]  got[$];
    bit           got_last[$];
    int  rdy_mode;     // 0 always ready, 1 alternating 1010, 2 not ready
    int  cyc, pops, vcnt, first_v, last_v, first_rd, done_cyc, coinc, unstable, go_cyc;
    int  gap_rem, gap_line, gap_words, valid_in_gap;
    bit  prev_stall;
    logic [31:0] prev_data;

    function automatic logic [511:0] mk_line(input bit seq);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = seq ? 32'(k) : $urandom();
        return l;
    endfunction

    task automatic push_line(input logic [511:0] l);
        fifo.push_back(l);
        for (int k = 0; k < 16; k++) exp_w.push_back(l[k*32 +: 32]);
    endtask

    task automatic clear_model();
        fifo.delete(); exp_w.delete(); got.delete(); got_last.delete();
        rdy_mode = 0; cyc = 0; pops = 0; vcnt = 0; first_v = -1; last_v = -1;
        first_rd = -1; done_cyc = -1; coinc = 0; unstable = 0; go_cyc = -1;
        gap_rem = 0; gap_line = -1; gap_words = 0; valid_in_gap = 0; prev_stall = 0;
    endtask

    // One clock: drive inputs, sample outputs, advance the FIFO model and record accepted words.
    task automatic tick(input bit g, input logic [64:0] n);
        bit blk, acc;
        @(negedge clk);
        go = g;
        num_lines = n;
        out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((cyc % 2) == 0) : 1'b0;
        blk = (gap_rem > 0) && (pops == gap_line) && (got.size() >= gap_words);
        dma_empty = (fifo.size() == 0) || blk;
        dma_rd_data = (fifo.size() != 0) ? fifo[0] : {16{32'hDEAD_BEEF}};
        #1;
        if (g) go_cyc = cyc;
        acc = out_valid && out_ready;
        if (prev_stall && out_valid && out_data !== prev_data) unstable++;
        if (prev_stall && !out_valid) unstable++;
        if (blk) begin
            gap_rem--;
            if (out_valid && !acc) valid_in_gap++;
        end
        if (acc) begin
            got.push_back(out_data);
            got_last.push_back(out_last);
        end
        if (out_valid) begin
            vcnt++;
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (dma_rd_en) begin
            pops++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            if (first_rd < 0) first_rd = cyc;
            if (acc && (got.size() % 16) == 0) coinc++;
        end
        if (done && !g && done_cyc < 0) done_cyc = cyc;
        prev_stall = out_valid && !out_ready && !g;
        prev_data = out_data;
        cyc++;
    endtask

    task automatic test_reset();
        clear_model();
        fifo.push_back(mk_line(0));
        dma_empty = 1'b0;
        dma_rd_data = fifo[0];
        out_ready = 1'b1;
        #1;
        checks++;
        if ({dma_rd_en, out_valid, out_last, done} !== 4'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_outputs: rd_en=%b valid=%b last=%b done=%b data=%h, required all 0",
                     dma_rd_en, out_valid, out_last, done, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_lines();
        clear_model();
        fifo.push_back(mk_line(0));
        tick(1'b1, 65'd0);
        for (int i = 0; i < 5; i++) tick(1'b0, 65'd0);
        checks++;
        if (done_cyc !== go_cyc + 1) begin
            failures++;
            $display("FAIL zero_done_timing: done at cycle %0d, required %0d", done_cyc, go_cyc + 1);
        end
        checks++;
        if (pops !== 0 || vcnt !== 0) begin
            failures++;
            $display("FAIL zero_no_activity: pops=%0d valid_cycles=%0d, required 0 and 0", pops, vcnt);
        end
    endtask

    task automatic test_single_line();
        int nlast;
        clear_model();
        push_line(mk_line(1));
        tick(1'b1, 65'd1);
        for (int i = 0; i < 100 && done_cyc < 0; i++) tick(1'b0, 65'd0);
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL single_timeout: done=0 after 100 cycles, required 1");
        end
        checks++;
        if (got.size() !== 16) begin
            failures++;
            $display("FAIL single_count: words=%0d, required 16", got.size());
        end
        nlast = 0;
        for (int k = 0; k < got.size() && k < 16; k++) begin
            checks++;
            if (got[k] !== 32'(k)) begin
                failures++;
                $display("FAIL single_word[%0d]: got %h, required %h", k, got[k], 32'(k));
            end
            if (got_last[k]) nlast++;
        end
        checks++;
        if (nlast !== 1 || got_last.size() != 16 || !got_last[15]) begin
            failures++;
            $display("FAIL single_last: last flags=%0d (on word 15: %b), required exactly one on word 15",
                     nlast, got_last.size() == 16 && got_last[15]);
        end
        checks++;
        if (done_cyc !== last_v + 1) begin
            failures++;
            $display("FAIL single_done_timing: done at %0d, required %0d", done_cyc, last_v + 1);
        end
        checks++;
        if (pops !== 1 || first_v !== first_rd + 1) begin
            failures++;
            $display("FAIL single_pop: pops=%0d first_valid=%0d first_rd=%0d, required 1 pop and valid one cycle after",
                     pops, first_v, first_rd);
        end
    endtask

    task automatic run_and_compare(input string name, input int budget);
        for (int i = 0; i < budget && done_cyc < 0; i++) tick(1'b0, 65'd0);
        checks++;
        if (done_cyc < 0) begin
            failures++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, budget);
        end
        checks++;
        if (got.size() !== exp_w.size()) begin
            failures++;
            $display("FAIL %s_count: words=%0d, required %0d", name, got.size(), exp_w.size());
        end
        for (int k = 0; k < got.size() && k < exp_w.size(); k++) begin
            checks++;
            if (got[k] !== exp_w[k] || got_last[k] !== (k == exp_w.size() - 1)) begin
                failures++;
                $display("FAIL %s_word[%0d]: got %h last=%b, required %h last=%b",
                         name, k, got[k], got_last[k], exp_w[k], k == exp_w.size() - 1);
            end
        end
        checks++;
        if (done_cyc !== last_v + 1) begin
            failures++;
            $display("FAIL %s_done_timing: done at %0d, required %0d", name, done_cyc, last_v + 1);
        end
    endtask

    task automatic test_back_to_back();
        clear_model();
        for (int l = 0; l < 4; l++) push_line(mk_line(0));
        tick(1'b1, 65'd4);
        run_and_compare("b2b", 200);
        checks++;
        if (vcnt !== 64 || last_v - first_v + 1 !== 64) begin
            failures++;
            $display("FAIL b2b_bubbles: valid_cycles=%0d span=%0d, required 64 and 64", vcnt, last_v - first_v + 1);
        end
        checks++;
        if (coinc !== 3 || pops !== 4) begin
            failures++;
            $display("FAIL b2b_refill: refills_on_last_accept=%0d pops=%0d, required 3 and 4", coinc, pops);
        end
    endtask

    task automatic test_ready_toggle();
        clear_model();
        for (int l = 0; l < 2; l++) push_line(mk_line(0));
        rdy_mode = 1;
        tick(1'b1, 65'd2);
        run_and_compare("toggle", 300);
        checks++;
        if (unstable !== 0) begin
            failures++;
            $display("FAIL toggle_stable: unstable stall cycles=%0d, required 0", unstable);
        end
    endtask

    task automatic test_dma_gap();
        clear_model();
        for (int l = 0; l < 3; l++) push_line(mk_line(0));
        gap_line = 2;
        gap_words = 31;
        gap_rem = 20;
        tick(1'b1, 65'd3);
        run_and_compare("gap", 300);
        checks++;
        if ((last_v - first_v + 1) - vcnt !== 20 || valid_in_gap !== 0) begin
            failures++;
            $display("FAIL gap_bubble: idle cycles in run=%0d valid_during_gap=%0d, required 20 and 0",
                     (last_v - first_v + 1) - vcnt, valid_in_gap);
        end
    endtask

    task automatic test_abort();
        logic [511:0] l0, l1, l2;
        clear_model();
        l0 = mk_line(0); l1 = mk_line(0); l2 = mk_line(0);
        fifo.push_back(l0); fifo.push_back(l1); fifo.push_back(l2);
        for (int k = 0; k < 5; k++) exp_w.push_back(l0[k*32 +: 32]);
        for (int k = 0; k < 16; k++) exp_w.push_back(l1[k*32 +: 32]);
        tick(1'b1, 65'd2);
        for (int i = 0; i < 50 && got.size() < 5; i++) tick(1'b0, 65'd0);
        rdy_mode = 2;
        tick(1'b1, 65'd1);
        rdy_mode = 0;
        run_and_compare("abort", 100);
        checks++;
        if (pops !== 2 || fifo.size() !== 1) begin
            failures++;
            $display("FAIL abort_pops: pops=%0d lines_left=%0d, required 2 and 1", pops, fifo.size());
        end
    endtask

    task automatic test_async_reset();
        clear_model();
        for (int l = 0; l < 2; l++) push_line(mk_line(0));
        tick(1'b1, 65'd2);
        for (int i = 0; i < 8; i++) tick(1'b0, 65'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({dma_rd_en, out_valid, out_last, done} !== 4'b0 || out_data !== 32'h0) begin
            failures++;
            $display("FAIL async_reset: rd_en=%b valid=%b last=%b done=%b data=%h, required all 0",
                     dma_rd_en, out_valid, out_last, done, out_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_zero_lines();
        test_single_line();
        test_back_to_back();
        test_ready_toggle();
        test_dma_gap();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
